// File: rtl/pc_stack_unit.sv
// Program counter with a return-address stack for call and return.
// Commands are prioritised: reset, stall, ret, call, loadPC, incPC.
module pc_stack_unit #(
    parameter int unsigned               PC_WIDTH     = 32,
    parameter int unsigned               IMM_WIDTH    = 16,
    parameter int unsigned               STACK_DEPTH  = 8,
    parameter logic [PC_WIDTH-1:0]       RESET_VECTOR = '0,
    localparam int unsigned              AW = $clog2(STACK_DEPTH),
    localparam int unsigned              CW = AW + 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 stall,
    input  logic                 incPC,
    input  logic                 loadPC,
    input  logic                 selPC,
    input  logic                 relPC,
    input  logic                 call,
    input  logic                 ret,
    input  logic [IMM_WIDTH-1:0] immediate,
    input  logic [PC_WIDTH-1:0]  rd_data,
    output logic [PC_WIDTH-1:0]  wire_PC,
    output logic                 stack_empty,
    output logic                 stack_full,
    output logic [CW-1:0]        stack_cnt,
    output logic                 ovf_err,
    output logic                 unf_err
);

    logic [PC_WIDTH-1:0] pc_q, pc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic [PC_WIDTH-1:0] stack_q [STACK_DEPTH];

    logic [PC_WIDTH-1:0] pc_inc;
    logic [PC_WIDTH-1:0] imm_sext;
    logic [PC_WIDTH-1:0] imm_zext;
    logic [PC_WIDTH-1:0] target;
    logic [CW-1:0]       cnt_m1;
    logic [AW-1:0]       top_idx;
    logic [AW-1:0]       push_idx;
    logic                empty;
    logic                full;
    logic                push;

    assign pc_inc   = pc_q + PC_WIDTH'(1);
    assign imm_sext = PC_WIDTH'(signed'(immediate));
    assign imm_zext = PC_WIDTH'(immediate);
    assign target   = selPC ? rd_data
                    : (relPC ? pc_q + imm_sext : imm_zext);

    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(STACK_DEPTH));
    assign cnt_m1   = cnt_q - CW'(1);
    assign top_idx  = cnt_m1[AW-1:0];
    assign push_idx = cnt_q[AW-1:0];

    always_comb begin
        pc_d  = pc_q;
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        unf_d = unf_q;
        push  = 1'b0;
        if (stall) begin
            pc_d = pc_q;
        end else if (ret) begin
            if (!empty) begin
                pc_d  = stack_q[top_idx];
                cnt_d = cnt_m1;
            end else begin
                pc_d  = pc_inc;
                unf_d = 1'b1;
            end
        end else if (call) begin
            pc_d = target;
            if (!full) begin
                push  = 1'b1;
                cnt_d = cnt_q + CW'(1);
            end else begin
                ovf_d = 1'b1;
            end
        end else if (loadPC) begin
            pc_d = target;
        end else if (incPC) begin
            pc_d = pc_inc;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            pc_q  <= RESET_VECTOR;
            cnt_q <= '0;
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    // Entry storage is not reset; the count alone decides validity.
    always_ff @(posedge clk) begin
        if (!rstn && push) begin
            stack_q[push_idx] <= pc_inc;
        end
    end

    assign wire_PC     = pc_q;
    assign stack_cnt   = cnt_q;
    assign stack_empty = empty;
    assign stack_full  = full;
    assign ovf_err     = ovf_q;
    assign unf_err     = unf_q;

endmodule

// File: tb/tb_pc_stack_unit.sv
// Scoreboarded bench for pc_stack_unit using a behavioural reference model.
module tb_pc_stack_unit;

    logic        clk = 1'b0;
    logic        rstn, stall, incPC, loadPC, selPC, relPC, call, ret;
    logic [15:0] immediate;
    logic [31:0] rd_data;
    logic [31:0] wire_PC;
    logic        stack_empty, stack_full, ovf_err, unf_err;
    logic [3:0]  stack_cnt;

    typedef struct {
        logic [31:0] pc;
        int          cnt;
        bit          ovf;
        bit          unf;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_stk[$];
    bit          m_ovf, m_unf;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    pc_stack_unit dut (
        .clk(clk), .rstn(rstn), .stall(stall), .incPC(incPC),
        .loadPC(loadPC), .selPC(selPC), .relPC(relPC),
        .call(call), .ret(ret), .immediate(immediate),
        .rd_data(rd_data), .wire_PC(wire_PC),
        .stack_empty(stack_empty), .stack_full(stack_full),
        .stack_cnt(stack_cnt), .ovf_err(ovf_err), .unf_err(unf_err)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model(input bit r, st, rt, cl, ld, inc, sel, rel,
                         input logic [15:0] imm, input logic [31:0] rd);
        logic [31:0] tgt;
        exp_t e;
        tgt = sel ? rd : (rel ? m_pc + {{16{imm[15]}}, imm} : {16'h0, imm});
        if (r) begin
            m_pc = 32'h0; m_stk.delete(); m_ovf = 0; m_unf = 0;
        end else if (st) begin
        end else if (rt) begin
            if (m_stk.size() > 0) m_pc = m_stk.pop_back();
            else begin m_pc = m_pc + 32'd1; m_unf = 1; end
        end else if (cl) begin
            if (m_stk.size() < 8) m_stk.push_back(m_pc + 32'd1);
            else m_ovf = 1;
            m_pc = tgt;
        end else if (ld) begin
            m_pc = tgt;
        end else if (inc) begin
            m_pc = m_pc + 32'd1;
        end
        e.pc = m_pc; e.cnt = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf;
        exp_q.push_back(e);
    endtask

    task automatic cyc(input string tag, input bit r, st, rt, cl, ld,
                       inc, sel, rel, input logic [15:0] imm,
                       input logic [31:0] rd);
        exp_t e;
        rstn = r; stall = st; ret = rt; call = cl; loadPC = ld;
        incPC = inc; selPC = sel; relPC = rel; immediate = imm;
        rd_data = rd;
        model(r, st, rt, cl, ld, inc, sel, rel, imm, rd);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = exp_q.pop_front();
            chk({tag, "_pc"}, wire_PC, e.pc);
            chk({tag, "_cnt"}, 32'(stack_cnt), 32'(e.cnt));
            chk({tag, "_empty"}, 32'(stack_empty), 32'(e.cnt == 0));
            chk({tag, "_full"}, 32'(stack_full), 32'(e.cnt == 8));
            chk({tag, "_ovf"}, 32'(ovf_err), 32'(e.ovf));
            chk({tag, "_unf"}, 32'(unf_err), 32'(e.unf));
        end
    endtask

    // Shorthands: r st rt cl ld inc sel rel imm rd
    task automatic rst_c();
        cyc("rst", 1, 0, 0, 0, 0, 0, 0, 0, 16'h0, 32'h0);
    endtask
    task automatic inc_c();
        cyc("inc", 0, 0, 0, 0, 0, 1, 0, 0, 16'h0, 32'h0);
    endtask
    task automatic ldr(input logic [31:0] rd);
        cyc("ldr", 0, 0, 0, 0, 1, 0, 1, 0, 16'h0, rd);
    endtask
    task automatic calli(input logic [15:0] imm);
        cyc("call", 0, 0, 0, 1, 0, 0, 0, 0, imm, 32'h0);
    endtask
    task automatic ret_c();
        cyc("ret", 0, 0, 1, 0, 0, 0, 0, 0, 16'h0, 32'h0);
    endtask

    initial begin
        rstn = 1; stall = 0; incPC = 0; loadPC = 0; selPC = 0;
        relPC = 0; call = 0; ret = 0; immediate = '0; rd_data = '0;
        m_pc = 0; m_ovf = 0; m_unf = 0;

        rst_c(); rst_c();
        chk("reset_pc", wire_PC, 32'h0);
        inc_c(); inc_c(); inc_c();
        chk("inc3_pc", wire_PC, 32'h3);
        cyc("rst_mid", 1, 0, 0, 0, 0, 1, 0, 0, 16'h0, 32'h0);
        chk("rst_mid_pc", wire_PC, 32'h0);

        cyc("ld10", 0, 0, 0, 0, 1, 0, 0, 0, 16'h0010, 32'h0);
        ldr(32'h1234);
        chk("jmp_rd", wire_PC, 32'h1234);
        cyc("rel", 0, 0, 0, 0, 1, 0, 0, 1, 16'hFFFC, 32'h0);
        chk("jmp_rel", wire_PC, 32'h1230);
        cyc("abs", 0, 0, 0, 0, 1, 0, 0, 0, 16'h8000, 32'h0);
        chk("jmp_zext", wire_PC, 32'h8000);

        ldr(32'h100);
        calli(16'h200); chk("nest1", wire_PC, 32'h200);
        calli(16'h300); chk("nest2", wire_PC, 32'h300);
        ret_c();        chk("nest3", wire_PC, 32'h201);
        ret_c();        chk("nest4", wire_PC, 32'h101);

        for (int i = 0; i < 9; i++) calli(16'(16'h1000 + i * 16));
        chk("ovf_pc", wire_PC, 32'h1080);
        chk("ovf_flag", 32'(ovf_err), 32'd1);
        for (int i = 0; i < 9; i++) ret_c();
        chk("unf_flag", 32'(unf_err), 32'd1);

        rst_c();
        calli(16'h0400);
        cyc("stall", 0, 1, 1, 1, 0, 1, 0, 0, 16'h0500, 32'h0);
        cyc("prio_ret", 0, 0, 1, 1, 0, 1, 0, 0, 16'h0500, 32'h0);
        chk("prio_ret_pc", wire_PC, 32'h1);
        cyc("prio_ld", 0, 0, 0, 0, 1, 1, 1, 0, 16'h0, 32'hABCD);
        chk("prio_ld_pc", wire_PC, 32'hABCD);

        ldr(32'hFFFF_FFFF); inc_c();
        chk("wrap_inc", wire_PC, 32'h0);
        ldr(32'hFFFF_FFFF); calli(16'h0040); ret_c();
        chk("wrap_push", wire_PC, 32'h0);
        cyc("rst_call", 1, 0, 0, 1, 0, 0, 0, 0, 16'h0040, 32'h0);

        for (int i = 0; i < 300; i++) begin
            cyc("rnd", ($urandom % 40) == 0, ($urandom % 6) == 0,
                ($urandom % 4) == 0, ($urandom % 3) == 0,
                ($urandom % 3) == 0, ($urandom % 2) == 0,
                ($urandom % 2) == 0, ($urandom % 2) == 0,
                16'($urandom), $urandom);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pc_stack_unit.md
Name: pc_stack_unit

Overview:
Parametrised next-generation program counter for the generalised processor. It supports increment, absolute jumps (register or immediate), PC-relative branches, and subroutine call/return through an internal return-address stack (LIFO). It sits between the control unit, which drives the one-hot-ish command strobes, and instruction fetch, which consumes wire_PC. Stall, stack status and sticky error flags go to the control unit.

Parameters:
PC_WIDTH, 32, width of PC, rd_data and return addresses
IMM_WIDTH, 16, width of the immediate field (must be <= PC_WIDTH)
STACK_DEPTH, 8, number of return-address entries (power of two, >= 2)
RESET_VECTOR, 0, PC value loaded on reset

Ports:
clk  input  1  system clock, all state updates on rising edge
rstn  input  1  synchronous, active-high reset (asserted = 1 resets the block)
stall  input  1  freeze PC and stack this cycle
incPC  input  1  PC <= PC+1
loadPC  input  1  jump to the selected target
selPC  input  1  target select: 1 = rd_data, 0 = immediate-based
relPC  input  1  when selPC=0: 1 = PC + sext(immediate), 0 = zext(immediate)
call  input  1  push PC+1, then jump to the selected target
ret  input  1  pop the top of stack into PC
immediate  input  IMM_WIDTH  jump/branch immediate
rd_data  input  PC_WIDTH  register-sourced target
wire_PC  output  PC_WIDTH  current PC (registered)
stack_empty  output  1  no valid entries
stack_full  output  1  STACK_DEPTH valid entries
stack_cnt  output  clog2(STACK_DEPTH)+1  number of valid entries
ovf_err  output  1  sticky: call issued while full
unf_err  output  1  sticky: ret issued while empty

Behaviour:
- Reset (rstn=1 at posedge): PC=RESET_VECTOR, stack_cnt=0, stack_empty=1, stack_full=0, ovf_err=0, unf_err=0. Reset overrides every other input, including a call/ret already in flight. Stack RAM contents need not be cleared.
- Target mux (combinational): selPC=1 -> rd_data; selPC=0,relPC=0 -> zero-extended immediate; selPC=0,relPC=1 -> PC + sign-extended immediate, modulo 2^PC_WIDTH. relPC is ignored when selPC=1.
- Command priority per cycle (highest first): rstn > stall > ret > call > loadPC > incPC > hold. Lower-priority strobes asserted in the same cycle are ignored with no side effects.
- stall: PC, stack, counters and flags all hold.
- ret, stack not empty: PC <= top entry; stack_cnt decrements.
- ret, stack empty: PC <= PC+1; unf_err <= 1; stack unchanged.
- call, stack not full: entry[stack_cnt] <= PC+1; stack_cnt increments; PC <= target.
- call, stack full: PC <= target; push is dropped; ovf_err <= 1; existing entries are not overwritten.
- loadPC: PC <= target. incPC: PC <= PC+1. No strobe asserted: PC holds.
- Wrap-around: PC+1 and relative addition wrap modulo 2^PC_WIDTH with no flag. The pushed PC+1 also wraps.
- Latency: every update is visible on wire_PC and the status outputs one cycle after the sampling edge. There is no combinational path from inputs to outputs.
- stack_empty = (stack_cnt==0) and stack_full = (stack_cnt==STACK_DEPTH); both are derived from the registered count.
- ovf_err and unf_err are sticky; only reset clears them.

Test Plan:
- Reset/increment: rstn=1 for 2 cycles, then incPC for 3 cycles -> wire_PC = 0,1,2,3. Assert rstn mid-sequence -> PC=0 on the next cycle.
- Jumps: PC=0x10. loadPC, selPC=1, rd_data=0x1234 -> PC=0x1234. Then loadPC, selPC=0, relPC=1, imm=16'hFFFC -> PC=0x1230. Then relPC=0, imm=0x8000 -> PC=0x00008000.
- Call/return nesting: from PC=0x100 call imm 0x200, then from 0x200 call imm 0x300, then ret, ret -> PC = 0x200, 0x300, 0x201, 0x101. stack_cnt = 1,2,1,0.
- Overflow/underflow: 9 calls with STACK_DEPTH=8 -> stack_full=1 after 8, ovf_err=1 after the 9th, PC = 9th target. Then 9 rets -> 8 correct pops, the 9th gives PC+1 and unf_err=1.
- Priority/stall: assert call+ret+incPC together with stall=1 -> nothing changes. Same strobes without stall -> ret only. loadPC+incPC together -> jump only.
- Wrap: PC=0xFFFFFFFF, incPC -> PC=0. A call from 0xFFFFFFFF pushes 0.
